// File: rtl/vga_timing_pkg.sv
// Shared raster constants and geometry helpers for the VGA timing generator.
// Defaults describe 640x480@60 on a 25.175 MHz pixel clock.
package vga_timing_pkg;

  localparam int DEF_H_FRONT = 16;
  localparam int DEF_H_SYNC  = 96;
  localparam int DEF_H_BACK  = 48;
  localparam int DEF_H_ACT   = 640;
  localparam int DEF_V_FRONT = 10;
  localparam int DEF_V_SYNC  = 2;
  localparam int DEF_V_BACK  = 33;
  localparam int DEF_V_ACT   = 480;

  // Raster counters and coordinate outputs share this width (totals up to 2048).
  localparam int CNT_W = 11;

  function automatic int total(input int front, input int sync, input int back, input int act);
    return front + sync + back + act;
  endfunction

  function automatic int blank(input int front, input int sync, input int back);
    return front + sync + back;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus sync and active decode.
// Region order along the axis is front porch, sync, back porch, active.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   FRONT = DEF_H_FRONT,
  parameter int   SYNC  = DEF_H_SYNC,
  parameter int   BACK  = DEF_H_BACK,
  parameter int   ACT   = DEF_H_ACT,
  parameter logic POL   = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_wrap,
  output logic             o_sync,
  output logic             o_active
);

  localparam logic [CNT_W-1:0] L_LAST    = CNT_W'(total(FRONT, SYNC, BACK, ACT) - 1);
  localparam logic [CNT_W-1:0] L_SYNC_LO = CNT_W'(FRONT);
  localparam logic [CNT_W-1:0] L_SYNC_HI = CNT_W'(FRONT + SYNC);
  localparam logic [CNT_W-1:0] L_ACT_LO  = CNT_W'(blank(FRONT, SYNC, BACK));

  logic [CNT_W-1:0] r_cnt;

  assign o_wrap = i_inc & (r_cnt == L_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_cnt <= '0;
    else if (i_inc) r_cnt <= o_wrap ? '0 : r_cnt + CNT_W'(1);
  end

  assign o_cnt    = r_cnt;
  assign o_sync   = ((r_cnt >= L_SYNC_LO) && (r_cnt < L_SYNC_HI)) ? POL : ~POL;
  assign o_active = (r_cnt >= L_ACT_LO);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator with a lead-ahead pixel request port, linear read address,
// and a registered output stage that keeps colour aligned with HS/VS/BLANK.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_FRONT = DEF_H_FRONT,
  parameter int   H_SYNC  = DEF_H_SYNC,
  parameter int   H_BACK  = DEF_H_BACK,
  parameter int   H_ACT   = DEF_H_ACT,
  parameter int   V_FRONT = DEF_V_FRONT,
  parameter int   V_SYNC  = DEF_V_SYNC,
  parameter int   V_BACK  = DEF_V_BACK,
  parameter int   V_ACT   = DEF_V_ACT,
  parameter logic HS_POL  = 1'b0,
  parameter logic VS_POL  = 1'b0,
  parameter int   LEAD    = 3,
  parameter int   CW      = 10,
  parameter int   AW      = 22
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic [CW-1:0] iRed,
  input  logic [CW-1:0] iGreen,
  input  logic [CW-1:0] iBlue,
  input  logic          iValid,
  input  logic          iClr_Underflow,
  output logic          oRequest,
  output logic [10:0]   oCurrent_X,
  output logic [10:0]   oCurrent_Y,
  output logic [AW-1:0] oAddress,
  output logic          oFrame_Start,
  output logic          oLine_Start,
  output logic [CW-1:0] oVGA_R,
  output logic [CW-1:0] oVGA_G,
  output logic [CW-1:0] oVGA_B,
  output logic          oVGA_HS,
  output logic          oVGA_VS,
  output logic          oVGA_BLANK,
  output logic          oVGA_SYNC,
  output logic          oVGA_CLOCK,
  output logic          oUnderflow
);

  // Pixel handshake: a request in cycle n must be answered with iValid=1 and
  // data in cycle n+LEAD. There is no backpressure; a missing answer on an
  // active pixel is an underflow and that pixel is shown black.

  localparam logic [CNT_W-1:0] L_REQ_LO  = CNT_W'(blank(H_FRONT, H_SYNC, H_BACK) - LEAD);
  localparam logic [CNT_W-1:0] L_REQ_HI  = CNT_W'(total(H_FRONT, H_SYNC, H_BACK, H_ACT) - LEAD);
  localparam logic [CNT_W-1:0] L_V_BLANK = CNT_W'(blank(V_FRONT, V_SYNC, V_BACK));

  logic [CNT_W-1:0] w_h, w_v;
  logic             w_h_wrap, w_v_wrap;
  logic             w_hs, w_vs, w_h_act, w_v_act;
  logic             w_active, w_req, w_pix_ok, w_underrun;

  vga_axis_counter #(
    .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .ACT(H_ACT), .POL(HS_POL)
  ) u_h_axis (
    .i_clk(iCLK), .i_rst_n(iRST_N), .i_inc(1'b1),
    .o_cnt(w_h), .o_wrap(w_h_wrap), .o_sync(w_hs), .o_active(w_h_act)
  );

  vga_axis_counter #(
    .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .ACT(V_ACT), .POL(VS_POL)
  ) u_v_axis (
    .i_clk(iCLK), .i_rst_n(iRST_N), .i_inc(w_h_wrap),
    .o_cnt(w_v), .o_wrap(w_v_wrap), .o_sync(w_vs), .o_active(w_v_act)
  );

  assign w_active   = w_h_act & w_v_act;
  assign w_req      = w_v_act & (w_h >= L_REQ_LO) & (w_h < L_REQ_HI);
  assign w_pix_ok   = w_active & iValid;
  assign w_underrun = w_active & ~iValid;

  logic [AW-1:0] r_addr;
  logic          r_sof;
  logic          r_hs, r_vs, r_blank, r_uf;
  logic [CW-1:0] r_red, r_green, r_blue;

  // r_sof is high exactly when the counters sit at (0,0): it resets to 1 and
  // otherwise follows the end-of-frame wrap from the previous cycle.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_sof  <= 1'b1;
      r_addr <= '0;
    end else begin
      r_sof <= w_v_wrap;
      if (r_sof)      r_addr <= '0;
      else if (w_req) r_addr <= r_addr + AW'(1);
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_hs    <= ~HS_POL;
      r_vs    <= ~VS_POL;
      r_blank <= 1'b0;
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
      r_uf    <= 1'b0;
    end else begin
      r_hs    <= w_hs;
      r_vs    <= w_vs;
      r_blank <= w_active;
      r_red   <= w_pix_ok ? iRed   : '0;
      r_green <= w_pix_ok ? iGreen : '0;
      r_blue  <= w_pix_ok ? iBlue  : '0;
      r_uf    <= w_underrun | (r_uf & ~iClr_Underflow);
    end
  end

  assign oRequest     = w_req;
  assign oCurrent_X   = w_req ? (w_h - L_REQ_LO)  : '0;
  assign oCurrent_Y   = w_req ? (w_v - L_V_BLANK) : '0;
  assign oAddress     = r_addr;
  assign oFrame_Start = iRST_N & r_sof;
  assign oLine_Start  = iRST_N & (w_h == '0);
  assign oVGA_R       = r_red;
  assign oVGA_G       = r_green;
  assign oVGA_B       = r_blue;
  assign oVGA_HS      = r_hs;
  assign oVGA_VS      = r_vs;
  assign oVGA_BLANK   = r_blank;
  assign oVGA_SYNC    = 1'b1;
  assign oVGA_CLOCK   = ~iCLK;
  assign oUnderflow   = r_uf;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small raster (plus inverted-polarity and default
// copies) driven by a pixel-source model and checked against a frame-level model.
module tb_vga_timing_gen;

  localparam int HF = 4, HSY = 6, HBK = 5, HA = 20;
  localparam int VF = 2, VSY = 2, VBK = 3, VA = 8;
  localparam int LEAD = 3, CW = 10, AW = 22;
  localparam int HB = HF + HSY + HBK, HT = HB + HA;
  localparam int VB = VF + VSY + VBK, VT = VB + VA;
  localparam int FT = HT * VT;
  localparam int DHT = 800, DVT = 525;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [CW-1:0] red, green, blue;
  logic          valid, clr;

  logic          req, fs, ls, hs, vs, blank, sync, vclk, uf;
  logic [10:0]   cx, cy;
  logic [AW-1:0] addr;
  logic [CW-1:0] vr, vg, vb;

  logic          p_req, p_fs, p_ls, p_hs, p_vs, p_blank, p_sync, p_vclk, p_uf;
  logic [10:0]   p_cx, p_cy;
  logic [AW-1:0] p_addr;
  logic [CW-1:0] p_r, p_g, p_b;

  logic          d_req, d_fs, d_ls, d_hs, d_vs, d_blank, d_sync, d_vclk, d_uf;
  logic [10:0]   d_cx, d_cy;
  logic [21:0]   d_addr;
  logic [9:0]    d_r, d_g, d_b;

  vga_timing_gen #(
    .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HBK), .H_ACT(HA),
    .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VBK), .V_ACT(VA),
    .HS_POL(1'b0), .VS_POL(1'b0), .LEAD(LEAD), .CW(CW), .AW(AW)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n), .iRed(red), .iGreen(green), .iBlue(blue),
    .iValid(valid), .iClr_Underflow(clr), .oRequest(req), .oCurrent_X(cx),
    .oCurrent_Y(cy), .oAddress(addr), .oFrame_Start(fs), .oLine_Start(ls),
    .oVGA_R(vr), .oVGA_G(vg), .oVGA_B(vb), .oVGA_HS(hs), .oVGA_VS(vs),
    .oVGA_BLANK(blank), .oVGA_SYNC(sync), .oVGA_CLOCK(vclk), .oUnderflow(uf)
  );

  vga_timing_gen #(
    .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HBK), .H_ACT(HA),
    .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VBK), .V_ACT(VA),
    .HS_POL(1'b1), .VS_POL(1'b1), .LEAD(LEAD), .CW(CW), .AW(AW)
  ) dut_p (
    .iCLK(clk), .iRST_N(rst_n), .iRed(red), .iGreen(green), .iBlue(blue),
    .iValid(valid), .iClr_Underflow(clr), .oRequest(p_req), .oCurrent_X(p_cx),
    .oCurrent_Y(p_cy), .oAddress(p_addr), .oFrame_Start(p_fs), .oLine_Start(p_ls),
    .oVGA_R(p_r), .oVGA_G(p_g), .oVGA_B(p_b), .oVGA_HS(p_hs), .oVGA_VS(p_vs),
    .oVGA_BLANK(p_blank), .oVGA_SYNC(p_sync), .oVGA_CLOCK(p_vclk), .oUnderflow(p_uf)
  );

  vga_timing_gen dut_d (
    .iCLK(clk), .iRST_N(rst_n), .iRed(red), .iGreen(green), .iBlue(blue),
    .iValid(valid), .iClr_Underflow(clr), .oRequest(d_req), .oCurrent_X(d_cx),
    .oCurrent_Y(d_cy), .oAddress(d_addr), .oFrame_Start(d_fs), .oLine_Start(d_ls),
    .oVGA_R(d_r), .oVGA_G(d_g), .oVGA_B(d_b), .oVGA_HS(d_hs), .oVGA_VS(d_vs),
    .oVGA_BLANK(d_blank), .oVGA_SYNC(d_sync), .oVGA_CLOCK(d_vclk), .oUnderflow(d_uf)
  );

  // ---------------- reference model state ----------------
  int            t, h_c, v_c;
  bit            cur_valid, cur_clr, m_uf;
  logic [AW-1:0] exp_q[$];
  int            src_due[$];
  logic [AW-1:0] src_addr[$];
  int            drop_t = -1, clr_t = -1;
  bit            blank_rand = 1'b1;

  bit            e_req, e_fs, e_ls, e_hs, e_vs, e_blank, e_uf, e_hs_d, e_vs_d, e_ls_d;
  logic [10:0]   e_x, e_y;
  logic [AW-1:0] e_addr;
  logic [CW-1:0] e_r, e_g, e_b;

  int n_cmp = 0, n_err = 0;

  function automatic bit f_in(input int c, input int lo, input int n);
    return (c >= lo) && (c < lo + n);
  endfunction

  function automatic bit f_act(input int h, input int v);
    return (h >= HB) && (v >= VB);
  endfunction

  function automatic bit f_req(input int h, input int v);
    return (v >= VB) && (h >= HB - LEAD) && (h < HT - LEAD);
  endfunction

  function automatic logic [3*CW-1:0] f_col(input logic [AW-1:0] a);
    logic [AW-1:0] a3;
    a3 = a * AW'(3);
    return {a[CW-1:0], a3[CW-1:0], ~a[CW-1:0]};
  endfunction

  // Model of the raster at cycle t, plus the pixel source driving this cycle.
  task automatic set_current();
    logic [AW-1:0] a;
    h_c    = t % HT;
    v_c    = (t / HT) % VT;
    e_req  = f_req(h_c, v_c);
    e_x    = e_req ? 11'(h_c - (HB - LEAD)) : 11'd0;
    e_y    = e_req ? 11'(v_c - VB) : 11'd0;
    e_addr = AW'((v_c - VB) * HA + (h_c - (HB - LEAD)));
    e_fs   = (t % FT == 0);
    e_ls   = (h_c == 0);
    e_ls_d = (t % DHT == 0);
    if (src_due.size() > 0 && src_due[0] == t) begin
      a = src_addr.pop_front();
      void'(src_due.pop_front());
      {red, green, blue} = f_col(a);
      valid = (t != drop_t);
    end else begin
      red   = CW'($urandom);
      green = CW'($urandom);
      blue  = CW'($urandom);
      valid = blank_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    clr       = (t == clr_t);
    cur_valid = valid;
    cur_clr   = clr;
  endtask

  // Advance one clock; expectations for registered outputs come from the previous cycle.
  task automatic step();
    int ph, pv, pt;
    bit pact, pval, pclr;
    logic [AW-1:0] pa;
    ph = h_c; pv = v_c; pt = t;
    pact = f_act(ph, pv); pval = cur_valid; pclr = cur_clr;
    @(posedge clk); #1;
    e_hs    = f_in(ph, HF, HSY) ? 1'b0 : 1'b1;
    e_vs    = f_in(pv, VF, VSY) ? 1'b0 : 1'b1;
    e_blank = pact;
    {e_r, e_g, e_b} = '0;
    if (pact) begin
      pa = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      if (pval) {e_r, e_g, e_b} = f_col(pa);
    end
    e_uf   = (pact && !pval) ? 1'b1 : (pclr ? 1'b0 : m_uf);
    m_uf   = e_uf;
    e_hs_d = f_in(pt % DHT, 16, 96) ? 1'b0 : 1'b1;
    e_vs_d = f_in((pt / DHT) % DVT, 10, 2) ? 1'b0 : 1'b1;
    t++;
    set_current();
    @(negedge clk);
    if (req) begin
      src_due.push_back(t + LEAD);
      src_addr.push_back(addr);
    end
    if (e_req) exp_q.push_back(e_addr);
  endtask

  // Called with rst_n already low; releases mid-cycle so cycle t=0 is (0,0).
  task automatic release_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b1;
    t = 0; m_uf = 1'b0; drop_t = -1; clr_t = -1;
    exp_q.delete(); src_due.delete(); src_addr.delete();
    e_hs = 1'b1; e_vs = 1'b1; e_blank = 1'b0; e_uf = 1'b0;
    e_r = '0; e_g = '0; e_b = '0; e_hs_d = 1'b1; e_vs_d = 1'b1;
    set_current();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_cmp++; if (hs !== 1'b1)    begin n_err++; $display("FAIL reset_hs: got %b want 1", hs); end
    n_cmp++; if (vs !== 1'b1)    begin n_err++; $display("FAIL reset_vs: got %b want 1", vs); end
    n_cmp++; if (p_hs !== 1'b0)  begin n_err++; $display("FAIL reset_hs_pol1: got %b want 0", p_hs); end
    n_cmp++; if (p_vs !== 1'b0)  begin n_err++; $display("FAIL reset_vs_pol1: got %b want 0", p_vs); end
    n_cmp++; if (blank !== 1'b0) begin n_err++; $display("FAIL reset_blank: got %b want 0", blank); end
    n_cmp++; if ({vr, vg, vb} !== '0) begin n_err++; $display("FAIL reset_colour: got %h want 0", {vr, vg, vb}); end
    n_cmp++; if (uf !== 1'b0)    begin n_err++; $display("FAIL reset_uf: got %b want 0", uf); end
    n_cmp++; if (fs !== 1'b0 || ls !== 1'b0) begin n_err++; $display("FAIL reset_starts: got fs=%b ls=%b want 0 0", fs, ls); end
    n_cmp++; if (req !== 1'b0 || addr !== '0) begin n_err++; $display("FAIL reset_req_addr: got req=%b addr=%0d want 0 0", req, addr); end
    n_cmp++; if (sync !== 1'b1 || vclk !== ~clk) begin n_err++; $display("FAIL reset_sync_clock: got sync=%b vclk=%b want 1 %b", sync, vclk, ~clk); end
    release_reset();
    n_cmp++; if (fs !== 1'b1 || ls !== 1'b1) begin n_err++; $display("FAIL first_cycle_starts: got fs=%b ls=%b want 1 1", fs, ls); end
    n_cmp++; if (d_fs !== 1'b1)  begin n_err++; $display("FAIL first_cycle_fs_default: got %b want 1", d_fs); end
  endtask

  task automatic test_frame();
    int hs_lo = 0, vs_lo = 0, fs_n = 0, req_n = 0, blk_n = 0, d_hs_lo = 0;
    logic [AW-1:0] last_a = '0;
    blank_rand = 1'b1;
    for (int i = 0; i < 2 * FT; i++) begin
      step();
      n_cmp++; if (req !== e_req) begin n_err++; $display("FAIL frame_req t=%0d: got %b want %b", t, req, e_req); end
      n_cmp++; if (cx !== e_x || cy !== e_y) begin n_err++; $display("FAIL frame_xy t=%0d: got %0d,%0d want %0d,%0d", t, cx, cy, e_x, e_y); end
      if (e_req) begin
        n_cmp++; if (addr !== e_addr) begin n_err++; $display("FAIL frame_addr t=%0d: got %0d want %0d", t, addr, e_addr); end
      end
      n_cmp++; if (fs !== e_fs || ls !== e_ls) begin n_err++; $display("FAIL frame_starts t=%0d: got %b%b want %b%b", t, fs, ls, e_fs, e_ls); end
      n_cmp++; if (hs !== e_hs || vs !== e_vs || blank !== e_blank) begin n_err++; $display("FAIL frame_sync t=%0d: got hs%b vs%b bl%b want hs%b vs%b bl%b", t, hs, vs, blank, e_hs, e_vs, e_blank); end
      n_cmp++; if (p_hs !== ~e_hs || p_vs !== ~e_vs) begin n_err++; $display("FAIL frame_sync_pol1 t=%0d: got %b%b want %b%b", t, p_hs, p_vs, ~e_hs, ~e_vs); end
      n_cmp++; if ({vr, vg, vb} !== {e_r, e_g, e_b}) begin n_err++; $display("FAIL frame_colour t=%0d: got %h want %h", t, {vr, vg, vb}, {e_r, e_g, e_b}); end
      n_cmp++; if (uf !== e_uf) begin n_err++; $display("FAIL frame_uf t=%0d: got %b want %b", t, uf, e_uf); end
      n_cmp++; if (d_hs !== e_hs_d || d_vs !== e_vs_d || d_ls !== e_ls_d) begin n_err++; $display("FAIL default_sync t=%0d: got %b%b%b want %b%b%b", t, d_hs, d_vs, d_ls, e_hs_d, e_vs_d, e_ls_d); end
      if (i < FT) begin
        hs_lo += int'(!hs); vs_lo += int'(!vs); fs_n += int'(fs);
        req_n += int'(req); blk_n += int'(blank);
        if (req) last_a = addr;
      end
      if (i < DHT) d_hs_lo += int'(!d_hs);
    end
    n_cmp++; if (hs_lo != HSY * VT) begin n_err++; $display("FAIL hs_low_count: got %0d want %0d", hs_lo, HSY * VT); end
    n_cmp++; if (vs_lo != VSY * HT) begin n_err++; $display("FAIL vs_low_count: got %0d want %0d", vs_lo, VSY * HT); end
    n_cmp++; if (fs_n != 1) begin n_err++; $display("FAIL frame_start_count: got %0d want 1", fs_n); end
    n_cmp++; if (req_n != HA * VA) begin n_err++; $display("FAIL request_count: got %0d want %0d", req_n, HA * VA); end
    n_cmp++; if (blk_n != HA * VA) begin n_err++; $display("FAIL visible_count: got %0d want %0d", blk_n, HA * VA); end
    n_cmp++; if (last_a != AW'(HA * VA - 1)) begin n_err++; $display("FAIL last_address: got %0d want %0d", last_a, HA * VA - 1); end
    n_cmp++; if (d_hs_lo != 96) begin n_err++; $display("FAIL default_hs_low: got %0d want 96", d_hs_lo); end
  endtask

  task automatic test_underflow();
    int t0, t1;
    blank_rand = 1'b0;
    t0 = t + LEAD + 2 + int'($urandom_range(0, FT));
    while (!f_act(t0 % HT, (t0 / HT) % VT)) t0++;
    drop_t = t0;
    clr_t  = t0 + 6 + int'($urandom_range(0, 8));
    while (t < clr_t + 2 * HT) begin
      step();
      n_cmp++; if ({vr, vg, vb} !== {e_r, e_g, e_b}) begin n_err++; $display("FAIL uf_colour t=%0d: got %h want %h", t, {vr, vg, vb}, {e_r, e_g, e_b}); end
      n_cmp++; if (uf !== e_uf) begin n_err++; $display("FAIL uf_model t=%0d: got %b want %b", t, uf, e_uf); end
      if (t == t0 + 1) begin
        n_cmp++; if ({vr, vg, vb} !== '0 || blank !== 1'b1) begin n_err++; $display("FAIL uf_pixel_black: got %h bl=%b want 0 bl=1", {vr, vg, vb}, blank); end
      end
      if (t > t0 && t <= clr_t) begin
        n_cmp++; if (uf !== 1'b1) begin n_err++; $display("FAIL uf_sticky t=%0d: got %b want 1", t, uf); end
      end
      if (t > clr_t) begin
        n_cmp++; if (uf !== 1'b0) begin n_err++; $display("FAIL uf_cleared t=%0d: got %b want 0", t, uf); end
      end
    end
    t1 = t + LEAD + 2;
    while (!f_act(t1 % HT, (t1 / HT) % VT)) t1++;
    drop_t = t1;
    clr_t  = t1;
    while (t < t1 + 3) begin
      step();
      if (t == t1 + 1) begin
        n_cmp++; if (uf !== 1'b1) begin n_err++; $display("FAIL uf_set_beats_clear: got %b want 1", uf); end
      end
    end
    clr_t = t + 2;
    while (t < clr_t + 2) step();
    n_cmp++; if (uf !== 1'b0) begin n_err++; $display("FAIL uf_final_clear: got %b want 0", uf); end
  endtask

  task automatic test_midreset();
    int n, t0, first_req_t;
    blank_rand = 1'b1;
    t0 = t + LEAD + 2;
    while (!f_act(t0 % HT, (t0 / HT) % VT)) t0++;
    drop_t = t0;
    n = int'($urandom_range(HT * VB, FT - 1));
    while (t < t0 + 1 || (t % FT) != n % FT) step();
    n_cmp++; if (uf !== 1'b1) begin n_err++; $display("FAIL midreset_uf_before: got %b want 1", uf); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (hs !== 1'b1 || vs !== 1'b1 || blank !== 1'b0) begin n_err++; $display("FAIL midreset_sync: got %b%b%b want 110", hs, vs, blank); end
    n_cmp++; if (p_hs !== 1'b0 || p_vs !== 1'b0) begin n_err++; $display("FAIL midreset_sync_pol1: got %b%b want 00", p_hs, p_vs); end
    n_cmp++; if ({vr, vg, vb} !== '0 || uf !== 1'b0) begin n_err++; $display("FAIL midreset_colour_uf: got %h uf=%b want 0 0", {vr, vg, vb}, uf); end
    n_cmp++; if (req !== 1'b0 || addr !== '0 || fs !== 1'b0 || ls !== 1'b0) begin n_err++; $display("FAIL midreset_req: got req=%b addr=%0d fs=%b ls=%b want all 0", req, addr, fs, ls); end
    release_reset();
    n_cmp++; if (fs !== 1'b1 || ls !== 1'b1) begin n_err++; $display("FAIL midreset_restart_starts: got %b%b want 11", fs, ls); end
    first_req_t = -1;
    for (int i = 0; i < FT + 5; i++) begin
      step();
      if (req && first_req_t < 0) begin
        first_req_t = t;
        n_cmp++; if (addr !== '0 || cx !== 11'd0 || cy !== 11'd0) begin n_err++; $display("FAIL midreset_first_req: got addr=%0d x=%0d y=%0d want 0 0 0", addr, cx, cy); end
      end
      n_cmp++; if (req !== e_req || (e_req && addr !== e_addr)) begin n_err++; $display("FAIL midreset_req_addr t=%0d: got %b/%0d want %b/%0d", t, req, addr, e_req, e_addr); end
      n_cmp++; if ({vr, vg, vb} !== {e_r, e_g, e_b} || hs !== e_hs || blank !== e_blank) begin n_err++; $display("FAIL midreset_out t=%0d: got %h %b%b want %h %b%b", t, {vr, vg, vb}, hs, blank, {e_r, e_g, e_b}, e_hs, e_blank); end
    end
    n_cmp++; if (first_req_t != VB * HT + HB - LEAD) begin n_err++; $display("FAIL midreset_first_req_time: got %0d want %0d", first_req_t, VB * HT + HB - LEAD); end
  endtask

  initial begin
    red = '0; green = '0; blue = '0; valid = 1'b0; clr = 1'b0;
    t = 0; h_c = 0; v_c = 0; cur_valid = 1'b0; cur_clr = 1'b0; m_uf = 1'b0;
    test_reset();
    test_frame();
    test_underflow();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: got timeout want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster generator and pixel pipeline for the camera-to-VGA display path. It produces HS/VS/BLANK from a single clock domain, issues pixel requests a configurable number of cycles ahead to the frame-buffer reader, and keeps a linear read address. It re-registers the returned colour so that colour, sync and blank leave the block on the same cycle. Underflow is detected and flagged when the pixel source misses a deadline.

## Interface
- H_FRONT, 16: horizontal front-porch pixels. H_SYNC, 96: horizontal sync pixels. H_BACK, 48: horizontal back-porch pixels. H_ACT, 640: active pixels per line.
- V_FRONT, 10; V_SYNC, 2; V_BACK, 33; V_ACT, 480: the same four values in lines.
- HS_POL, 0: asserted level of oVGA_HS. VS_POL, 0: asserted level of oVGA_VS.
- LEAD, 3: request-to-data latency of the pixel source in cycles. Legal range 1 ≤ LEAD < H_FRONT+H_SYNC+H_BACK.
- CW, 10: colour channel width. AW, 22: address width. Requires H_ACT·V_ACT ≤ 2^AW.
- iCLK, in, 1: pixel clock. This is the only clock.
- iRST_N, in, 1: asynchronous, active-low reset.
- iRed / iGreen / iBlue, in, CW each: pixel data. Must be valid LEAD cycles after the matching oRequest cycle.
- iValid, in, 1: the source asserts this alongside the data.
- iClr_Underflow, in, 1: one-cycle pulse that clears oUnderflow.
- oRequest, out, 1: asks the source for the pixel at oCurrent_X/oCurrent_Y/oAddress.
- oCurrent_X, out, 11 and oCurrent_Y, out, 11: coordinates of the requested pixel. Both are 0 when oRequest is low.
- oAddress, out, AW: linear address Y·H_ACT+X. Valid while oRequest is high.
- oFrame_Start, out, 1: one-cycle pulse when the counters are at h=0, v=0.
- oLine_Start, out, 1: one-cycle pulse at h=0 of every line.
- oVGA_R / oVGA_G / oVGA_B, out, CW each: registered colour. Forced to 0 during blanking or underflow.
- oVGA_HS, oVGA_VS, oVGA_BLANK, out, 1 each: registered sync and blank. oVGA_BLANK is active-low.
- oVGA_SYNC, out, 1: constant 1.
- oVGA_CLOCK, out, 1: equal to ~iCLK.
- oUnderflow, out, 1: sticky underflow flag.

## Operation
- Counters: H_TOTAL=H_FRONT+H_SYNC+H_BACK+H_ACT and V_TOTAL is formed the same way. h counts 0..H_TOTAL-1 and wraps to 0. v increments on every h wrap and wraps from V_TOTAL-1 to 0. Each line is exactly H_TOTAL cycles with no extra count.
- Region order within a line or frame: front porch, then sync, then back porch, then active. Active means h ≥ H_BLANK and v ≥ V_BLANK.
- HS is asserted (=HS_POL) for h in [H_FRONT, H_FRONT+H_SYNC-1]. VS is asserted (=VS_POL) for v in [V_FRONT, V_FRONT+V_SYNC-1], and VS changes only at h=0.
- Request window: combinational, high while v ≥ V_BLANK, h ≥ H_BLANK-LEAD and h < H_TOTAL-LEAD. X = h-(H_BLANK-LEAD) and Y = v-V_BLANK.
- The request window never crosses a line boundary, which follows from the LEAD < H_BLANK rule.
- Address counter:
  - Cleared to 0 when oFrame_Start is high.
  - Increments by 1 after every cycle in which oRequest is high.
  - After the last pixel it reaches H_ACT·V_ACT and holds until the next frame clear.
  - It is not computed with a multiplier.
- Output stage, evaluated on each clock from the current h/v:
  - oVGA_HS, oVGA_VS and oVGA_BLANK are registered from the decode.
  - Colour loads iRed/iGreen/iBlue when the pixel is active and iValid=1; otherwise colour loads 0.
- Underflow: an active pixel with iValid=0 sets oUnderflow on the next clock. iValid is ignored during blanking.
- oUnderflow clears on iClr_Underflow. If a set and a clear happen in the same cycle, the set wins.

## Timing
- Reset values:
  - h=0, v=0, address=0.
  - oVGA_HS=~HS_POL and oVGA_VS=~VS_POL.
  - oVGA_BLANK=0, colour=0, oUnderflow=0.
  - oFrame_Start and oLine_Start are 0 while reset is held.
- On the first cycle after reset release, the counters sit at (0,0), so oFrame_Start and oLine_Start are both high on that cycle.
- Latency from request to display:
  - A request in cycle n is answered by the source with data in cycle n+LEAD.
  - That pixel appears on oVGA_* at cycle n+LEAD+1, together with its own HS/VS/BLANK.
- oRequest, oCurrent_X/Y, oAddress, oFrame_Start and oLine_Start are combinational from the counters and have zero latency.
- Reset asserted mid-frame: every register goes to its reset value immediately, regardless of the clock. The raster restarts at (0,0). No partial line is emitted.

## Structure
- Shared package vga_timing_pkg holds:
  - The default 640×480@60 constants.
  - A function total(front, sync, back, act).
  - A localparam-style helper for H_BLANK and V_BLANK.
- One sub-module, vga_axis_counter:
  - Instantiated once for horizontal and once for vertical.
  - Provides the counter, wrap output, sync decode and active decode.
  - Takes an increment enable, which is constant 1 for h and the h wrap for v.

## Test plan
- Defaults, one frame:
  - oVGA_HS is low for exactly 96 cycles in every 800.
  - oVGA_VS is low for exactly 1600 cycles in every 420000.
  - oFrame_Start pulses once per 420000 cycles.
- Request window:
  - First oRequest occurs at h=157, v=45 with X=0, Y=0, address 0.
  - Each active line has 640 consecutive requests; there are 480 such lines.
  - The last request carries address 307199; the next frame starts again at 0.
- Source model with LEAD=3 returning R=address[9:0]:
  - At the first cycle with oVGA_BLANK=1, oVGA_R=0.
  - The last visible pixel of line 0 shows R=639.
  - Colour is 0 whenever oVGA_BLANK=0.
- Underflow:
  - iValid=0 for one active pixel: that pixel's colour is 0 and oUnderflow rises on the next cycle and stays high.
  - iClr_Underflow then clears it.
  - iValid=0 during blanking does not set the flag.
  - A set and a clear in the same cycle leave the flag at 1.
- HS_POL=1, VS_POL=1: sync outputs are inverted relative to defaults and have reset value 0.
- iRST_N pulsed low at h=400, v=200:
  - Outputs reach reset values without waiting for a clock edge.
  - After release, oFrame_Start is high on the first cycle.
  - The address restarts at 0.
